// File: rtl/irq_ctrl_pkg.sv
// Shared register offsets, FSM encoding and VECTOR bit positions for the interrupt controller.
package irq_ctrl_pkg;

    localparam logic [1:0] REG_PENDING = 2'd0;
    localparam logic [1:0] REG_MASK    = 2'd1;
    localparam logic [1:0] REG_VECTOR  = 2'd2;
    localparam logic [1:0] REG_EOI     = 2'd3;

    localparam int VEC_INSERV = 7;
    localparam int VEC_VALID  = 6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RAISE   = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder, lowest set bit wins; purely combinational, no backpressure.
module irq_prio_enc (
    input  logic [7:0] req,
    output logic [2:0] idx,
    output logic       any
);

    // Scan downwards so the lowest set index is the last assignment made.
    always_comb begin
        idx = 3'd0;
        any = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (req[i]) begin
                idx = 3'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Bus-mapped interrupt aggregator: captures peripheral requests, arbitrates and raises one CPU line.
// Reads return data one cycle after the address; CPU_RAISE is held until CPU_ACK, then EOI re-arms.
module irq_controller
    import irq_ctrl_pkg::*;
#(
    parameter int         N_SRC     = 8,
    parameter logic [7:0] BASE_ADDR = 8'hE0
) (
    input  logic             CLK,
    input  logic             RESET,
    inout  wire  [7:0]       BUS_DATA,
    input  logic [7:0]       BUS_ADDR,
    input  logic             BUS_WE,
    input  logic [N_SRC-1:0] SRC_RAISE,
    output logic [N_SRC-1:0] SRC_ACK,
    output logic             CPU_RAISE,
    input  logic             CPU_ACK
);

    localparam logic [8:0] SRC_ONES = (9'd1 << N_SRC) - 9'd1;
    localparam logic [7:0] SRC_BITS = SRC_ONES[7:0];

    logic [7:0] raise_w, ack_q, capture, pending_q, mask_q, pend_clr;
    logic [7:0] addr_off, vector, rd_mux, rd_dat_q;
    logic [2:0] idx_q, enc_idx;
    logic       enc_any, valid_q, inserv_q, cpu_raise_q, rd_en_q, in_range;
    logic       wr_pend, wr_mask, wr_eoi, latch_req, take_ack, eoi_done;
    irq_state_t state_q, state_d;

    assign raise_w  = 8'(SRC_RAISE);
    assign capture  = raise_w & ~ack_q & SRC_BITS;

    assign addr_off = BUS_ADDR - BASE_ADDR;
    assign in_range = (addr_off[7:2] == 6'd0);
    assign wr_pend  = BUS_WE && in_range && (addr_off[1:0] == REG_PENDING);
    assign wr_mask  = BUS_WE && in_range && (addr_off[1:0] == REG_MASK);
    assign wr_eoi   = BUS_WE && in_range && (addr_off[1:0] == REG_EOI);

    // New captures are OR-ed in after clears so a same-cycle set always survives.
    assign pend_clr = (wr_pend  ? BUS_DATA         : 8'h00)
                    | (take_ack ? (8'd1 << idx_q)  : 8'h00);

    irq_prio_enc u_prio_enc (
        .req (pending_q & mask_q),
        .idx (enc_idx),
        .any (enc_any)
    );

    always_comb begin
        vector             = 8'h00;
        vector[VEC_INSERV] = inserv_q;
        vector[VEC_VALID]  = valid_q;
        vector[2:0]        = idx_q;
    end

    always_comb begin
        rd_mux = 8'h00;
        case (addr_off[1:0])
            REG_PENDING: rd_mux = pending_q;
            REG_MASK:    rd_mux = mask_q;
            REG_VECTOR:  rd_mux = vector;
            default:     rd_mux = 8'h00;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        latch_req = 1'b0;
        take_ack  = 1'b0;
        eoi_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enc_any) begin
                    state_d   = ST_RAISE;
                    latch_req = 1'b1;
                end
            end
            ST_RAISE: begin
                if (CPU_ACK) begin
                    state_d  = ST_SERVICE;
                    take_ack = 1'b1;
                end
            end
            ST_SERVICE: begin
                if (wr_eoi) begin
                    state_d  = ST_IDLE;
                    eoi_done = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= ST_IDLE;
            ack_q       <= 8'h00;
            pending_q   <= 8'h00;
            mask_q      <= 8'h00;
            idx_q       <= 3'd0;
            valid_q     <= 1'b0;
            inserv_q    <= 1'b0;
            cpu_raise_q <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_dat_q    <= 8'h00;
        end else begin
            state_q     <= state_d;
            ack_q       <= capture;
            pending_q   <= ((pending_q & ~pend_clr) | capture) & SRC_BITS;
            if (wr_mask)
                mask_q  <= BUS_DATA & SRC_BITS;
            if (latch_req)
                idx_q   <= enc_idx;
            if (latch_req)
                valid_q <= 1'b1;
            else if (eoi_done)
                valid_q <= 1'b0;
            if (take_ack)
                inserv_q <= 1'b1;
            else if (eoi_done)
                inserv_q <= 1'b0;
            cpu_raise_q <= (state_q == ST_RAISE) && !CPU_ACK;
            rd_en_q     <= in_range && !BUS_WE;
            rd_dat_q    <= rd_mux;
        end
    end

    assign SRC_ACK   = ack_q[N_SRC-1:0];
    assign CPU_RAISE = cpu_raise_q;
    assign BUS_DATA  = rd_en_q ? rd_dat_q : 8'bz;

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed scenarios plus random request/mask/clear traffic vs a bitset model.
module tb_irq_controller;

    localparam logic [7:0] BASE = 8'hE0;
    localparam logic [1:0] O_PEND = 2'd0, O_MASK = 2'd1, O_VEC = 2'd2, O_EOI = 2'd3;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    wire  [7:0] BUS_DATA;
    logic [7:0] BUS_ADDR = 8'h00;
    logic       BUS_WE = 1'b0;
    logic [7:0] SRC_RAISE = 8'h00;
    logic [7:0] SRC_ACK;
    logic       CPU_RAISE;
    logic       CPU_ACK = 1'b0;

    logic       drv_en = 1'b0;
    logic [7:0] drv_dat = 8'h00;
    assign BUS_DATA = drv_en ? drv_dat : 8'bz;

    int n_cmp = 0;
    int n_err = 0;

    // Abstract model: the set of pending sources and the enabled set.
    logic [7:0] m_pend = 8'h00;
    logic [7:0] m_mask = 8'h00;

    irq_controller #(.N_SRC(8), .BASE_ADDR(BASE)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .BUS_DATA  (BUS_DATA),
        .BUS_ADDR  (BUS_ADDR),
        .BUS_WE    (BUS_WE),
        .SRC_RAISE (SRC_RAISE),
        .SRC_ACK   (SRC_ACK),
        .CPU_RAISE (CPU_RAISE),
        .CPU_ACK   (CPU_ACK)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] lowest(input logic [7:0] x);
        for (int i = 0; i < 8; i++)
            if (x[i]) return 3'(i);
        return 3'd0;
    endfunction

    task automatic bus_rd(input logic [1:0] off, output logic [7:0] dat);
        @(negedge CLK);
        BUS_ADDR = BASE + 8'(off);
        BUS_WE   = 1'b0;
        @(negedge CLK);
        dat      = BUS_DATA;
        BUS_ADDR = 8'h00;
    endtask

    task automatic bus_wr(input logic [1:0] off, input logic [7:0] dat);
        @(negedge CLK);
        BUS_ADDR = BASE + 8'(off);
        BUS_WE   = 1'b1;
        drv_en   = 1'b1;
        drv_dat  = dat;
        @(negedge CLK);
        BUS_WE   = 1'b0;
        drv_en   = 1'b0;
        BUS_ADDR = 8'h00;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] off, input logic [7:0] exp);
        logic [7:0] d;
        bus_rd(off, d);
        chk(tag, d, exp);
    endtask

    // Peripherals hold each request until they see its acknowledge.
    task automatic drop_on_ack(input string tag);
        for (int i = 0; i < 6 && SRC_RAISE != 8'h00; i++) begin
            @(negedge CLK);
            SRC_RAISE = SRC_RAISE & ~SRC_ACK;
        end
        chk({tag, "_ack_timeout"}, SRC_RAISE, 8'h00);
        SRC_RAISE = 8'h00;
    endtask

    task automatic raise_src(input logic [7:0] bits);
        @(negedge CLK);
        SRC_RAISE = bits;
        m_pend    = m_pend | bits;
        drop_on_ack("raise");
    endtask

    task automatic expect_raise(input string tag, input logic exp, input int cycles);
        logic seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge CLK);
            if (CPU_RAISE) seen = 1'b1;
            if (exp && seen) break;
        end
        chk(tag, 8'(seen), 8'(exp));
    endtask

    task automatic cpu_ack_pulse;
        @(negedge CLK);
        CPU_ACK = 1'b1;
        @(negedge CLK);
        CPU_ACK = 1'b0;
    endtask

    // One full ISR round trip for the highest-priority eligible source.
    task automatic service(input string tag);
        logic [2:0] idx;
        idx = lowest(m_pend & m_mask);
        expect_raise({tag, "_raise"}, 1'b1, 4);
        rd_chk({tag, "_vec"}, O_VEC, 8'h40 | 8'(idx));
        cpu_ack_pulse();
        m_pend[idx] = 1'b0;
        chk({tag, "_drop"}, 8'(CPU_RAISE), 8'h00);
        rd_chk({tag, "_vec_isr"}, O_VEC, 8'hC0 | 8'(idx));
        rd_chk({tag, "_pend_isr"}, O_PEND, m_pend);
        bus_wr(O_EOI, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d;
        logic [7:0] r;

        // Reset with every peripheral requesting.
        RESET     = 1'b0;
        SRC_RAISE = 8'hFF;
        repeat (3) @(negedge CLK);
        chk("rst_cpu_raise", 8'(CPU_RAISE), 8'h00);
        chk("rst_src_ack", SRC_ACK, 8'h00);
        RESET  = 1'b1;
        m_pend = 8'hFF;
        drop_on_ack("rst_recapture");
        rd_chk("rst_mask", O_MASK, 8'h00);
        rd_chk("rst_vec", O_VEC, 8'h00);
        rd_chk("rst_pend_recaptured", O_PEND, m_pend);
        bus_wr(O_PEND, 8'hFF);
        m_pend = 8'h00;
        rd_chk("w1c_all", O_PEND, 8'h00);

        // Masked capture, then enable.
        @(negedge CLK);
        SRC_RAISE = 8'h08;
        @(negedge CLK);
        chk("cap_ack_hi", SRC_ACK, 8'h08);
        SRC_RAISE = 8'h00;
        @(negedge CLK);
        chk("cap_ack_lo", SRC_ACK, 8'h00);
        m_pend = 8'h08;
        expect_raise("masked_no_raise", 1'b0, 4);
        rd_chk("masked_pend", O_PEND, 8'h08);
        bus_wr(O_MASK, 8'h08);
        m_mask = 8'h08;
        expect_raise("unmask_raise", 1'b1, 2);
        rd_chk("unmask_vec", O_VEC, 8'h43);
        service("unmask");

        // Priority between two simultaneous sources.
        bus_wr(O_MASK, 8'hFF);
        m_mask = 8'hFF;
        raise_src(8'h22);
        service("prio_first");
        chk("prio_model_pend", m_pend, 8'h20);
        service("prio_second");
        expect_raise("prio_quiet", 1'b0, 4);

        // Capture and W1C on the same bit in the same cycle.
        bus_wr(O_MASK, 8'h00);
        m_mask = 8'h00;
        @(negedge CLK);
        SRC_RAISE = 8'h04;
        BUS_ADDR  = BASE + 8'(O_PEND);
        BUS_WE    = 1'b1;
        drv_en    = 1'b1;
        drv_dat   = 8'h04;
        @(negedge CLK);
        SRC_RAISE = 8'h00;
        BUS_WE    = 1'b0;
        drv_en    = 1'b0;
        BUS_ADDR  = 8'h00;
        rd_chk("set_beats_w1c", O_PEND, 8'h04);

        // EOI while idle is ignored.
        bus_wr(O_EOI, 8'h5A);
        bus_rd(O_VEC, d);
        chk("eoi_idle_vec", d & 8'hC0, 8'h00);
        rd_chk("eoi_idle_pend", O_PEND, 8'h04);
        expect_raise("eoi_idle_quiet", 1'b0, 4);

        // CPU_ACK during SERVICE is ignored.
        bus_wr(O_MASK, 8'h01);
        m_mask = 8'h01;
        m_pend = 8'h04;
        raise_src(8'h01);
        expect_raise("svc_raise", 1'b1, 4);
        cpu_ack_pulse();
        m_pend[0] = 1'b0;
        raise_src(8'h05);
        cpu_ack_pulse();
        expect_raise("svc_ack_quiet", 1'b0, 4);
        rd_chk("svc_ack_vec", O_VEC, 8'hC0);
        rd_chk("svc_ack_pend", O_PEND, 8'h05);
        bus_wr(O_EOI, 8'h00);
        service("after_svc");
        bus_wr(O_PEND, 8'h04);
        m_pend = 8'h00;
        expect_raise("svc_done_quiet", 1'b0, 4);

        // Randomised traffic; the controller is brought back to idle every round.
        for (int it = 0; it < 40; it++) begin
            r = 8'($urandom_range(1, 255));
            case ($urandom_range(0, 2))
                0: raise_src(r);
                1: begin bus_wr(O_MASK, r); m_mask = r; end
                default: begin bus_wr(O_PEND, r); m_pend = m_pend & ~r; end
            endcase
            for (int k = 0; k < 8 && (m_pend & m_mask) != 8'h00; k++)
                service("rnd");
            expect_raise("rnd_quiet", 1'b0, 4);
            rd_chk("rnd_pend", O_PEND, m_pend);
        end

        // Asynchronous reset while the request is raised.
        bus_wr(O_MASK, 8'hFF);
        m_mask = 8'hFF;
        raise_src(8'h02);
        expect_raise("mid_raise", 1'b1, 4);
        #2;
        RESET = 1'b0;
        #1;
        chk("async_rst_raise", 8'(CPU_RAISE), 8'h00);
        @(negedge CLK);
        RESET  = 1'b1;
        m_pend = 8'h00;
        m_mask = 8'h00;
        rd_chk("post_rst_pend", O_PEND, 8'h00);
        rd_chk("post_rst_mask", O_MASK, 8'h00);
        rd_chk("post_rst_vec", O_VEC, 8'h00);
        expect_raise("post_rst_quiet", 1'b0, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
